lwpi_wb_sequencer: RTL
======================

LWPI_WB_SEQUENCER -- requirements
Module: lwpi_wb_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, register/data width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-lwpostinc counter.
REQ-003 SHALL have one clock and one reset: clk rising-edge; rst asynchronous, active-high.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 is_lwpi  input  1  decoded current instruction is lwpostinc.
REQ-007 rd_addr  input  5  lwpostinc destination register.
REQ-008 rs1_addr  input  5  lwpostinc base register.
REQ-009 load_data  input  XLEN  data memory read result for the current address.
REQ-010 rs1_inc  input  XLEN  rs1 + sign-extended immediate, from the ALU.
REQ-011 wb_en_in / wb_addr_in / wb_data_in  input  1/5/XLEN  normal single-write writeback request.
REQ-012 rf_we / rf_waddr / rf_wdata  output  1/5/XLEN  to the register file's single write port.
REQ-013 stall  output  1  holds the PC and the instruction for the next cycle.
REQ-014 busy  output  1  high while in SECOND.
REQ-015 lwpi_count  output  CNT_W  count of completed lwpostinc instructions.

Function
REQ-016 SHALL implement FSM states IDLE and SECOND.
REQ-017 IDLE, is_lwpi=0: rf_we=wb_en_in && wb_addr_in!=0, rf_waddr=wb_addr_in, rf_wdata=wb_data_in; stall=0.
REQ-018 IDLE, is_lwpi=1, rs1_addr!=0, rs1_addr!=rd_addr: write rd=load_data (rf_we=0 if rd_addr=0); capture rs1_addr and rs1_inc into internal registers; stall=1 combinationally; next state SECOND.
REQ-019 IDLE, is_lwpi=1, rs1_addr=0: single cycle; write rd=load_data only (no write if rd_addr=0); stall=0; stay IDLE; lwpi_count increments.
REQ-020 IDLE, is_lwpi=1, rs1_addr=rd_addr!=0: single cycle; write rd=load_data only (the load value wins, no increment); stall=0; stay IDLE; lwpi_count increments.
REQ-021 SECOND: rf_we=1, rf_waddr=captured rs1, rf_wdata=captured rs1_inc; stall=0; busy=1; next state IDLE; lwpi_count increments at this edge.
REQ-022 In SECOND the block SHALL ignore is_lwpi, rd_addr, rs1_addr, load_data, rs1_inc and all wb_*_in inputs; the replayed instruction SHALL NOT restart the sequence.
REQ-023 Latency: a two-write lwpostinc occupies exactly 2 cycles; every other instruction occupies 1 cycle.
REQ-024 rf_we SHALL never be 1 with rf_waddr=0.
REQ-025 lwpi_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-026 Outputs in REQ-017 to REQ-021 are combinational from the state and the inputs; the only registered values are the state, the captured rs1/value, and the counter.

Reset
REQ-027 On rst assertion the block SHALL immediately enter IDLE, clear the capture registers and clear lwpi_count to 0.
REQ-028 While rst=1, rf_we=0, stall=0 and busy=0, regardless of the inputs.
REQ-029 If rst is asserted in SECOND, the pending rs1 write SHALL be dropped and SHALL NOT appear after reset.
REQ-030 The first rising clk edge after rst deasserts SHALL process inputs as in IDLE.

Verification
REQ-031 is_lwpi=1, rd=5, rs1=6, load_data=0xDEADBEEF, rs1_inc=0x104 -> cycle 1: write x5=0xDEADBEEF, stall=1; cycle 2: write x6=0x104, busy=1, stall=0; lwpi_count=1.
REQ-032 is_lwpi=1, rd=7, rs1=7, load_data=0x11 -> single write x7=0x11, stall=0, no second cycle, lwpi_count increments.
REQ-033 is_lwpi=1, rd=0, rs1=3, rs1_inc=0x20 -> cycle 1: rf_we=0, stall=1; cycle 2: write x3=0x20.
REQ-034 In SECOND, drive is_lwpi=1 with new operands and wb_en_in=1 -> the output is only the captured rs1 write, then IDLE.
REQ-035 Assert rst in SECOND -> rf_we=0 and busy=0 immediately, no x6 write follows, lwpi_count=0.
REQ-036 Preload lwpi_count to 0xFFFF via 65535 lwpostinc completions, then run one more -> lwpi_count=0x0000.

Source files
------------

// File: rtl/lwpi_wb_sequencer.sv
// lwpi_wb_sequencer
//   Writeback sequencer for the lwpostinc (load word, post-increment)
//   instruction on a register file that has a single write port.
//   - Most instructions pass their one write straight through.
//   - A two-write lwpostinc writes rd with the load data in its first cycle
//     and raises stall. The base register update (rs1 <= rs1_inc) is
//     captured and written in the following cycle (state SECOND).
//   - lwpi_count counts completed lwpostinc instructions and wraps.
//
// Ports
//   clk, rst                              clock, async active-high reset
//   is_lwpi, rd_addr, rs1_addr            decoded lwpostinc and its registers
//   load_data, rs1_inc                    load result and incremented base
//   wb_en_in, wb_addr_in, wb_data_in      normal single-write request
//   rf_we, rf_waddr, rf_wdata             register file write port
//   stall                                 hold PC/instruction next cycle
//   busy                                  high while in SECOND
//   lwpi_count                            completed lwpostinc count
module lwpi_wb_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_lwpi,
  input  logic [4:0]       rd_addr,
  input  logic [4:0]       rs1_addr,
  input  logic [XLEN-1:0]  load_data,
  input  logic [XLEN-1:0]  rs1_inc,
  input  logic             wb_en_in,
  input  logic [4:0]       wb_addr_in,
  input  logic [XLEN-1:0]  wb_data_in,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             stall,
  output logic             busy,
  output logic [CNT_W-1:0] lwpi_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [4:0]        cap_rs1_reg, cap_rs1_next;
  logic [XLEN-1:0]   cap_val_reg, cap_val_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cap_rs1_reg <= '0;
      cap_val_reg <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cap_rs1_reg <= cap_rs1_next;
      cap_val_reg <= cap_val_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cap_rs1_next = cap_rs1_reg;
    cap_val_next = cap_val_reg;
    count_next   = count_reg;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    stall        = 1'b0;
    busy         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (is_lwpi) begin
          rf_waddr = rd_addr;
          rf_wdata = load_data;
          rf_we    = (rd_addr != 5'd0);
          if (rs1_addr != 5'd0 && rs1_addr != rd_addr) begin
            // Base update deferred to the next cycle; replay is held off by stall.
            stall        = 1'b1;
            cap_rs1_next = rs1_addr;
            cap_val_next = rs1_inc;
            state_next   = SECOND;
          end else begin
            // rs1 is x0 (no update) or aliases rd (load value wins).
            count_next = count_reg + 1'b1;
          end
        end else begin
          rf_waddr = wb_addr_in;
          rf_wdata = wb_data_in;
          rf_we    = wb_en_in && (wb_addr_in != 5'd0);
        end
      end
      SECOND: begin
        // All inputs are ignored here: the replayed lwpostinc must not restart.
        rf_waddr   = cap_rs1_reg;
        rf_wdata   = cap_val_reg;
        rf_we      = (cap_rs1_reg != 5'd0);
        busy       = 1'b1;
        state_next = IDLE;
        count_next = count_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are combinational, so reset must mask them directly.
    if (rst) begin
      rf_we = 1'b0;
      stall = 1'b0;
      busy  = 1'b0;
    end
  end

  assign lwpi_count = count_reg;

endmodule
